// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// rtl/mem_port_arbiter_arb_rr2.sv - two-input round-robin picker owning the last-grant register
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Under contention the port that did not win last time goes first.
    always_comb begin
        if (req == 2'b11) begin
            gnt = (last_q == PORT_D) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD    = WORD_W,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [WORD-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [WORD-1:0] if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [WORD-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_rdata,
    output logic            busy
);

    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [WORD-1:0] mem_addr_q, mem_addr_d;
    logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic [WORD-1:0] if_rdata_q, if_rdata_d;
    logic            if_err_q, if_err_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [WORD-1:0] d_rdata_q, d_rdata_d;
    logic            d_err_q, d_err_d;

    logic            grant_ok;
    logic [1:0]      arb_gnt;
    logic            timed_out;
    logic [WORD-1:0] resp_data;

    assign grant_ok = (state_q == ST_IDLE) && !reset;

    arb_rr2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({d_req, if_req}),
        .advance (grant_ok),
        .gnt     (arb_gnt)
    );

    assign if_gnt = grant_ok && arb_gnt[0];
    assign d_gnt  = grant_ok && arb_gnt[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        timed_out   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        resp_data   = '0;

        if (state_q == ST_IDLE) begin
            if (if_gnt || d_gnt) begin
                state_d   = ST_BUSY;
                cnt_d     = '0;
                mem_req_d = 1'b1;
                if (d_gnt) begin
                    owner_d     = PORT_D;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                end else begin
                    owner_d     = PORT_IF;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = BE_FULL;
                end
            end
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            // An ack in the same cycle as the timeout is a normal completion.
            if (mem_ack || timed_out) begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                if (mem_ack && !mem_we_q) begin
                    resp_data = mem_rdata;
                end
                if (owner_q == PORT_D) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = resp_data;
                    d_err_d    = !mem_ack;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = resp_data;
                    if_err_d    = !mem_ack;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= PORT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: who owns the memory, how long it has waited, what it will return.
    bit          m_busy = 0;
    bit          m_owner = 0;
    int          m_waited = 0;
    bit          m_last = 1;
    logic        m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_be = 0;
    bit          m_if_rv = 0, m_d_rv = 0, m_if_err = 0, m_d_err = 0;
    logic [31:0] m_if_rdata = 0, m_d_rdata = 0;
    bit          g_if, g_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] rd;
        g_if = !reset && !m_busy && if_req && (!d_req || m_last);
        g_d  = !reset && !m_busy && d_req && (!if_req || !m_last);
        chk("if_gnt", if_gnt, g_if);
        chk("d_gnt", d_gnt, g_d);
        chk("mem_req", mem_req, m_busy);
        chk("busy", busy, m_busy);
        chk("if_rvalid", if_rvalid, m_if_rv);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("if_err", if_err, m_if_err);
        chk("d_rvalid", d_rvalid, m_d_rv);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("d_err", d_err, m_d_err);
        if (m_busy) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_be", mem_be, m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (reset) begin
            m_busy = 0; m_last = 1;
            m_if_rv = 0; m_d_rv = 0; m_if_err = 0; m_d_err = 0;
            m_if_rdata = 0; m_d_rdata = 0;
        end else begin
            m_if_rv = 0; m_d_rv = 0;
            if (m_busy) begin
                m_waited++;
                if (mem_ack || m_waited == TO) begin
                    rd = (mem_ack && !m_we) ? mem_rdata : 32'h0;
                    if (m_owner) begin
                        m_d_rv = 1; m_d_rdata = rd; m_d_err = !mem_ack;
                    end else begin
                        m_if_rv = 1; m_if_rdata = rd; m_if_err = !mem_ack;
                    end
                    m_busy = 0;
                end
            end else if (g_if || g_d) begin
                m_busy = 1; m_waited = 0; m_owner = g_d; m_last = g_d;
                if (g_d) begin
                    m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
                end else begin
                    m_we = 0; m_addr = if_addr; m_wdata = 0; m_be = 4'hF;
                end
            end
        end
        @(negedge clk);
    endtask

    int          cnt;
    int          reps;
    logic        gq[$];

    initial begin
        reset = 1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        @(negedge clk);
        #1; tick();
        #1; chk("rst_mem_addr", mem_addr, 32'h0); chk("rst_mem_be", mem_be, 4'h0); tick();

        // single fetch
        reset = 0; if_req = 1; if_addr = 32'h100;
        #1; chk("sf_gnt", if_gnt, 1'b1); tick();
        if_req = 0; if_addr = $urandom;
        #1; chk("sf_addr", mem_addr, 32'h100); chk("sf_be", mem_be, 4'hF); chk("sf_we", mem_we, 1'b0); tick();
        mem_ack = 1; mem_rdata = 32'h00500093;
        #1; chk("sf_req2", mem_req, 1'b1); tick();
        mem_ack = 0; mem_rdata = $urandom;
        #1; chk("sf_rvalid", if_rvalid, 1'b1); chk("sf_rdata", if_rdata, 32'h00500093); chk("sf_err", if_err, 1'b0); tick();

        // contention right after reset, store with immediate ack
        reset = 1; #1; tick(); reset = 0;
        if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        for (int c = 0; c < 5; c++) begin
            mem_ack = m_busy; mem_rdata = $urandom | 32'h1;
            #1;
            if (c == 0) chk("ct_if_first", {if_gnt, d_gnt}, 2'b10);
            if (c == 2) chk("ct_d_in_rv", {if_rvalid, d_gnt}, 2'b11);
            if (c == 3) begin
                chk("ct_we", mem_we, 1'b1); chk("ct_wdata", mem_wdata, 32'hDEADBEEF); chk("ct_be", mem_be, 4'h3);
            end
            if (c == 4) begin chk("ct_drv", d_rvalid, 1'b1); chk("ct_drdata", d_rdata, 32'h0); end
            tick();
            if (g_if) if_req = 0;
            if (g_d) d_req = 0;
        end

        // fairness: both ports always requesting
        if_req = 1; d_req = 1; d_we = 0;
        for (int c = 0; c < 20; c++) begin
            mem_ack = m_busy; mem_rdata = $urandom; d_addr = $urandom; if_addr = $urandom;
            #1;
            if (if_gnt) gq.push_back(1'b0);
            if (d_gnt) gq.push_back(1'b1);
            tick();
        end
        if_req = 0; d_req = 0; mem_ack = 0;
        reps = 0;
        for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1]) reps++;
        chk("fair_count", gq.size(), 10);
        chk("fair_repeats", reps, 0);
        chk("fair_first", gq[0], 1'b0);

        // watchdog timeout on a load, then a normal fetch
        d_req = 1; d_we = 0; d_addr = 32'h300; cnt = 0;
        for (int c = 0; c < 9; c++) begin
            mem_ack = (c == 7); mem_rdata = $urandom;
            if (c == 5) begin if_req = 1; if_addr = 32'h400; end
            #1;
            if (c == 0) chk("to_gnt", d_gnt, 1'b1);
            if (c <= 5 && mem_req) cnt++;
            if (c == 5) begin
                chk("to_rv", d_rvalid, 1'b1); chk("to_err", d_err, 1'b1); chk("to_rdata", d_rdata, 32'h0);
                chk("to_next_gnt", if_gnt, 1'b1);
            end
            if (c == 8) begin chk("to_if_rv", if_rvalid, 1'b1); chk("to_if_err", if_err, 1'b0); end
            tick();
            if (g_if) if_req = 0;
            if (g_d) d_req = 0;
        end
        chk("to_req_cycles", cnt, TO);

        // ack coinciding with the timeout
        d_req = 1; d_addr = 32'h500;
        for (int c = 0; c < 6; c++) begin
            mem_ack = (c == 4); mem_rdata = (c == 4) ? 32'h1234 : $urandom;
            #1;
            if (c == 5) begin
                chk("bd_rv", d_rvalid, 1'b1); chk("bd_err", d_err, 1'b0); chk("bd_rdata", d_rdata, 32'h1234);
            end
            tick();
            if (g_d) d_req = 0;
        end

        // reset in the second busy cycle, then a late ack
        d_req = 1; d_addr = 32'h600;
        for (int c = 0; c < 6; c++) begin
            reset = (c == 2); mem_ack = (c == 3); mem_rdata = $urandom;
            #1;
            if (c >= 3) begin
                chk("rm_rv", {if_rvalid, d_rvalid}, 2'b00);
                chk("rm_req", mem_req, 1'b0); chk("rm_busy", busy, 1'b0);
            end
            if (c == 3) begin chk("rm_addr", mem_addr, 32'h0); chk("rm_rdata", d_rdata, 32'h0); end
            tick();
            if (g_d) d_req = 0;
        end
        reset = 0; mem_ack = 0; if_req = 1; d_req = 1;
        #1; chk("rm_first", {if_gnt, d_gnt}, 2'b10); tick();
        if_req = 0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom % 200 == 0);
            if (!if_req && ($urandom % 3 == 0)) if_req = 1;
            if (!d_req && ($urandom % 3 == 0)) d_req = 1;
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_we = $urandom; d_be = $urandom;
            mem_ack = m_busy ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            mem_rdata = $urandom;
            #1; tick();
            if (g_if) if_req = 0;
            if (g_d) d_req = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
